dict_instr_expander: RTL and testbench
======================================

Name: dict_instr_expander

Overview:
- Downstream consumer of the dictionary lookup in the code-compression datapath.
- Accepts a stream of field tokens from the compressed fetch buffer. Each token is either a dictionary key or a raw uncompressed field.
- Drives the dictionary key port and takes back the expanded value. Assembles NUM_FIELDS fields into one full instruction.
- Presents the instruction to the decode stage over a valid/ready handshake.

Parameters:
KEY_WIDTH, 4, width of a compressed field (dictionary index)
VAL_WIDTH, 8, width of one uncompressed field
NUM_FIELDS, 4, fields per instruction; instruction width = NUM_FIELDS*VAL_WIDTH (32 by default)

Ports:
clk  input  1  single clock, all state on rising edge
resetn  input  1  synchronous active-low reset
flush  input  1  synchronous discard of partial and held instruction
tok_valid  input  1  upstream token valid
tok_ready  output  1  block accepts token this cycle
tok_is_key  input  1  1 = tok_data[KEY_WIDTH-1:0] is a dictionary key; 0 = tok_data is a raw field
tok_data  input  VAL_WIDTH  raw field, or key in low KEY_WIDTH bits (upper bits ignored when tok_is_key=1)
dict_key_out  output  KEY_WIDTH  key presented to dictionary; = tok_data[KEY_WIDTH-1:0], combinational
dict_val_in  input  VAL_WIDTH  dictionary value for dict_key_out, valid in the same cycle (combinational return)
out_valid  output  1  assembled instruction valid
out_ready  input  1  decode stage accepts
out_instr  output  NUM_FIELDS*VAL_WIDTH  instruction; field 0 (first token) in bits [VAL_WIDTH-1:0]
out_key_mask  output  NUM_FIELDS  bit f = 1 if field f came from the dictionary
instr_count  output  16  number of instructions delivered; saturates at 16'hFFFF

Behaviour:
- Reset (resetn=0 at posedge): state COLLECT, field index 0, out_valid=0, out_instr=0, out_key_mask=0, instr_count=0. Reset overrides flush and all handshakes.
- Token accept: a token is accepted when tok_valid && tok_ready.
- Field write on accept: field[idx] <= tok_is_key ? dict_val_in : tok_data; mask[idx] <= tok_is_key.
- State COLLECT:
  - tok_ready = ~flush; out_valid = 0.
  - Each accept increments idx.
  - Accept at idx = NUM_FIELDS-1: idx wraps to 0, state goes to HOLD. out_valid is 1 the next cycle (latency 1 cycle from the last token).
- State HOLD:
  - out_valid = 1; out_instr and out_key_mask are stable until the handshake.
  - tok_ready = out_ready && ~flush.
  - On out_valid && out_ready: instr_count increments (saturating).
  - If a token is accepted in the same cycle, it is written as field 0 of the next instruction and idx becomes 1. The state returns to COLLECT either way.
  - Exception for NUM_FIELDS=1: that token completes a new instruction, so the state stays in HOLD.
  - This back-to-back rule sustains one instruction per NUM_FIELDS cycles.
- No token is accepted in HOLD without out_ready, so there is no overwrite of a held instruction.
- Handshake rules:
  - tok_ready depends combinationally on out_ready and flush only, never on tok_valid.
  - out_valid never drops without a handshake, except on flush or reset.
- flush=1:
  - Next state COLLECT, idx 0, out_valid 0. tok_ready is forced 0, so a concurrent token is dropped (upstream retains it).
  - A concurrent out handshake is not counted.
  - Data registers need not clear.
- tok_valid low mid-instruction: idx holds and the partial fields are retained indefinitely.
- Field order: field f is the f-th accepted token after the previous completion or flush.

Test Plan:
- Bench dictionary model returns key+1. Send tokens {key 3, raw 8'hAA, key 0, raw 8'h55} with out_ready=1. Required: out_instr=32'h55_01_AA_04 and out_key_mask=4'b0101, both one cycle after the 4th token accept; instr_count=1.
- Continuous tok_valid with 8 tokens, out_ready=1 throughout. Required: two instructions, out_valid pulses 4 cycles apart, tok_ready never deasserted.
- Complete an instruction with out_ready=0 for 5 cycles. Required: tok_ready=0, out_instr stable, and no token consumed during the stall. On out_ready=1, the handshake occurs and a same-cycle token becomes field 0 of the next instruction.
- Accept 2 tokens, assert flush for 1 cycle, then send 4 new tokens. Required: only the new 4 fields appear in the output and instr_count increments by 1. A token offered during the flush cycle is not accepted.
- Assert resetn=0 while in HOLD. Required: out_valid=0, instr_count=0, idx=0 at the next edge. The first 4 tokens after reset form field 0..3.
- Preload instr_count via 65535 deliveries (or force it), then deliver one more. Required: instr_count stays 16'hFFFF.

Source files
------------

// File: rtl/dict_instr_expander.sv
// rtl/dict_instr_expander.sv - assembles dictionary-expanded field tokens into full instructions
//
// Ports:
//   clk, resetn      rising-edge clock, synchronous active-low reset
//   flush            discards the partial and the held instruction
//   tok_valid/ready  token handshake from the compressed fetch buffer
//   tok_is_key       token is a dictionary key (low KEY_WIDTH bits of tok_data)
//   tok_data         raw field or key
//   dict_key_out     key presented to the dictionary (combinational)
//   dict_val_in      dictionary value for dict_key_out, same cycle
//   out_valid/ready  instruction handshake to decode
//   out_instr        assembled instruction, field 0 in the low bits
//   out_key_mask     bit f set when field f came from the dictionary
//   instr_count      delivered instructions, saturating
module dict_instr_expander #(
  parameter int KEY_WIDTH  = 4,
  parameter int VAL_WIDTH  = 8,
  parameter int NUM_FIELDS = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            flush,
  input  logic                            tok_valid,
  output logic                            tok_ready,
  input  logic                            tok_is_key,
  input  logic [VAL_WIDTH-1:0]            tok_data,
  output logic [KEY_WIDTH-1:0]            dict_key_out,
  input  logic [VAL_WIDTH-1:0]            dict_val_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_FIELDS*VAL_WIDTH-1:0] out_instr,
  output logic [NUM_FIELDS-1:0]           out_key_mask,
  output logic [15:0]                     instr_count
);

  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [VAL_WIDTH-1:0]  field_q [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] mask_q;
  logic                  valid_q;
  logic [15:0]           count_q;

  logic                  accept;
  logic                  handshake;
  logic [VAL_WIDTH-1:0]  field_val;

  assign dict_key_out = tok_data[KEY_WIDTH-1:0];
  assign field_val    = tok_is_key ? dict_val_in : tok_data;

  // In HOLD a token may only enter in the cycle the held instruction leaves,
  // so the held fields are never overwritten while still on offer.
  assign tok_ready = ~flush & ((state_q == COLLECT) | out_ready);
  assign accept    = tok_valid & tok_ready;
  assign handshake = valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        field_q[i] <= '0;
      end
    end else if (flush) begin
      // Data registers keep their contents; only control state is discarded.
      state_q <= COLLECT;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        field_q[idx_q] <= field_val;
        mask_q[idx_q]  <= tok_is_key;
      end

      if (handshake && count_q != 16'hFFFF) begin
        count_q <= count_q + 16'd1;
      end

      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            if (accept && NUM_FIELDS == 1) begin
              // A single-field instruction is complete with this one token.
              idx_q   <= '0;
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              idx_q   <= accept ? IDX_W'(1) : '0;
              state_q <= COLLECT;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= COLLECT;
          idx_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_pack
    assign out_instr[f*VAL_WIDTH +: VAL_WIDTH] = field_q[f];
  end

  assign out_valid    = valid_q;
  assign out_key_mask = mask_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_dict_instr_expander.sv
// tb/tb_dict_instr_expander.sv - directed scoreboard bench for dict_instr_expander
module tb_dict_instr_expander;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        tok_valid;
  logic        tok_ready;
  logic        tok_is_key;
  logic [7:0]  tok_data;
  logic [3:0]  dict_key_out;
  logic [7:0]  dict_val_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [3:0]  out_key_mask;
  logic [15:0] instr_count;

  logic        s_tok_valid;
  logic        s_tok_ready;
  logic        s_tok_is_key;
  logic [7:0]  s_tok_data;
  logic [3:0]  s_dict_key_out;
  logic [7:0]  s_dict_val_in;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_instr;
  logic [0:0]  s_out_key_mask;
  logic [15:0] s_instr_count;

  always #5 clk = ~clk;

  assign dict_val_in   = {4'h0, dict_key_out} + 8'd1;
  assign s_dict_val_in = {4'h0, s_dict_key_out} + 8'd1;

  dict_instr_expander #(.KEY_WIDTH(4), .VAL_WIDTH(8), .NUM_FIELDS(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_key(tok_is_key),
    .tok_data(tok_data), .dict_key_out(dict_key_out), .dict_val_in(dict_val_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_key_mask(out_key_mask), .instr_count(instr_count)
  );

  dict_instr_expander #(.KEY_WIDTH(4), .VAL_WIDTH(8), .NUM_FIELDS(1)) dut_one (
    .clk(clk), .resetn(resetn), .flush(1'b0),
    .tok_valid(s_tok_valid), .tok_ready(s_tok_ready), .tok_is_key(s_tok_is_key),
    .tok_data(s_tok_data), .dict_key_out(s_dict_key_out), .dict_val_in(s_dict_val_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_instr(s_out_instr),
    .out_key_mask(s_out_key_mask), .instr_count(s_instr_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  mask;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          m_idx = 0;
  logic        m_hold = 1'b0;
  logic [15:0] m_count = '0;
  logic [31:0] m_instr = '0;
  logic [3:0]  m_mask = '0;
  logic        last_acc = 1'b0;
  logic        last_hs = 1'b0;
  int          acc_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check handshake outputs against the model, update the model
  // and scoreboard, advance past the edge, then check the counter.
  task automatic tick();
    logic       exp_ready;
    logic [7:0] v;
    exp_t       e;
    #1;
    exp_ready = !flush && (!m_hold || out_ready);
    last_acc  = 1'b0;
    last_hs   = 1'b0;
    if (!resetn) begin
      m_idx = 0; m_hold = 1'b0; m_count = '0; exp_q.delete();
    end else begin
      chk("tok_ready", {31'b0, tok_ready}, {31'b0, exp_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_hold});
      if (flush) begin
        m_idx = 0; m_hold = 1'b0; exp_q.delete();
      end else begin
        last_acc = tok_valid && exp_ready;
        last_hs  = m_hold && out_ready;
        if (last_hs) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_entry", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("out_instr", out_instr, e.instr);
            chk("out_key_mask", {28'b0, out_key_mask}, {28'b0, e.mask});
          end
          if (m_count != 16'hFFFF) m_count++;
          m_hold = 1'b0;
        end
        if (last_acc) begin
          acc_total++;
          v = tok_is_key ? ({4'h0, tok_data[3:0]} + 8'd1) : tok_data;
          m_instr[m_idx*8 +: 8] = v;
          m_mask[m_idx] = tok_is_key;
          if (m_idx == 3) begin
            e.instr = m_instr; e.mask = m_mask;
            exp_q.push_back(e);
            m_idx = 0; m_hold = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (resetn) chk("instr_count", {16'b0, instr_count}, {16'b0, m_count});
  endtask

  task automatic send(input logic key, input logic [7:0] data);
    tok_valid = 1'b1; tok_is_key = key; tok_data = data;
    tick();
    tok_valid = 1'b0;
  endtask

  task automatic idle();
    tok_valid = 1'b0;
    tick();
  endtask

  int          hs_cycles[$];
  int          ready_low;
  int          acc_before;
  logic [31:0] held;
  logic [15:0] cnt_before;

  initial begin
    resetn = 1'b0; flush = 1'b0; tok_valid = 1'b0; tok_is_key = 1'b0;
    tok_data = '0; out_ready = 1'b0;
    s_tok_valid = 1'b0; s_tok_is_key = 1'b0; s_tok_data = '0; s_out_ready = 1'b0;
    @(posedge clk); #1;
    tick();
    resetn = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr_count", {16'b0, instr_count}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_key_mask", {28'b0, out_key_mask}, 32'd0);
    chk("rst_tok_ready", {31'b0, tok_ready}, 32'd1);

    // Basic assembly and one-cycle latency.
    out_ready = 1'b1;
    send(1'b1, 8'h03);
    send(1'b0, 8'hAA);
    send(1'b1, 8'h00);
    send(1'b0, 8'h55);
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_instr", out_instr, 32'h5501AA04);
    chk("t1_mask", {28'b0, out_key_mask}, 32'h5);
    idle();
    chk("t1_count", {16'b0, instr_count}, 32'd1);

    // Eight back-to-back tokens.
    ready_low = 0;
    for (int i = 0; i < 8; i++) begin
      tok_valid = 1'b1; tok_is_key = i[0]; tok_data = 8'(8'h10 * i + i);
      #1;
      if (!tok_ready) ready_low++;
      tick();
      if (last_hs) hs_cycles.push_back(cyc);
    end
    tok_valid = 1'b0;
    idle();
    if (last_hs) hs_cycles.push_back(cyc);
    chk("t2_ready_low", ready_low, 32'd0);
    chk("t2_hs_count", hs_cycles.size(), 32'd2);
    if (hs_cycles.size() == 2) chk("t2_spacing", hs_cycles[1] - hs_cycles[0], 32'd4);
    chk("t2_count", {16'b0, instr_count}, 32'd3);

    // Stall with out_ready low.
    out_ready = 1'b0;
    send(1'b0, 8'h11); send(1'b1, 8'h0F); send(1'b0, 8'h33); send(1'b1, 8'h07);
    held = out_instr;
    chk("t3_held", held, 32'h08_33_10_11);
    acc_before = acc_total;
    tok_valid = 1'b1; tok_is_key = 1'b0; tok_data = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stable", out_instr, held);
    end
    chk("t3_no_consume", acc_total - acc_before, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t3_same_cycle_acc", {31'b0, last_acc}, 32'd1);
    send(1'b0, 8'hC4); send(1'b1, 8'h09); send(1'b0, 8'hC6);
    chk("t3_next_instr", out_instr, 32'hC6_0A_C4_C3);
    idle();

    // Flush mid-instruction.
    send(1'b0, 8'hE1); send(1'b0, 8'hE2);
    cnt_before = instr_count;
    flush = 1'b1; tok_valid = 1'b1; tok_is_key = 1'b0; tok_data = 8'hEE;
    #1;
    chk("t4_flush_ready", {31'b0, tok_ready}, 32'd0);
    tick();
    flush = 1'b0; tok_valid = 1'b0;
    send(1'b1, 8'h01); send(1'b0, 8'h22); send(1'b0, 8'h33); send(1'b1, 8'h0E);
    chk("t4_instr", out_instr, 32'h0F_33_22_02);
    idle();
    chk("t4_count_delta", {16'b0, instr_count - cnt_before}, 32'd1);

    // Reset while holding.
    out_ready = 1'b0;
    send(1'b0, 8'h91); send(1'b0, 8'h92); send(1'b0, 8'h93); send(1'b0, 8'h94);
    chk("t5_hold", {31'b0, out_valid}, 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t5_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_count", {16'b0, instr_count}, 32'd0);
    chk("t5_instr", out_instr, 32'd0);
    out_ready = 1'b1;
    send(1'b1, 8'h05); send(1'b0, 8'h77); send(1'b1, 8'h0A); send(1'b0, 8'h88);
    chk("t5_fields", out_instr, 32'h88_0B_77_06);
    idle();
    chk("t5_count_after", {16'b0, instr_count}, 32'd1);

    // Saturation on the single-field instance: one delivery per cycle.
    s_tok_valid = 1'b1; s_out_ready = 1'b1; s_tok_is_key = 1'b0; s_tok_data = 8'h3C;
    repeat (1000) @(posedge clk);
    #1;
    chk("sat_count_1000", {16'b0, s_instr_count}, 32'd999);
    chk("sat_valid", {31'b0, s_out_valid}, 32'd1);
    repeat (64536) @(posedge clk);
    #1;
    chk("sat_reach", {16'b0, s_instr_count}, 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", {16'b0, s_instr_count}, 32'hFFFF);
    chk("sat_instr", {24'b0, s_out_instr}, 32'h3C);
    chk("sat_ready", {31'b0, s_tok_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
